mcpu_core_exn_arbiter: RTL and testbench

MCPU_CORE_EXN_ARBITER -- requirements
Module: MCPU_CORE_exn_arbiter

---
 rtl/mcpu_core_exn_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mcpu_core_exn_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_core_exn_arbiter.sv
// mcpu_core_exn_arbiter
// Collects per-lane exception conditions for the bundle at the PC stage,
// picks the lowest faulting lane and captures its code, lane index and the
// bundle PC. The capture is held until the control unit acknowledges it.
// A fixed number of drain cycles follows before a new capture is possible.
//
// Ports
//   clkrst_core_clk     core clock (rising edge)
//   clkrst_core_rst_n   asynchronous active-low reset
//   pc_valid, pc_pc     bundle valid flag and bundle PC
//   inst_pf             bundle-wide instruction page fault (reported on lane 0)
//   invalid, data_pf    per-lane illegal-instruction / data page fault flags
//   dup_dest, div_zero,
//   syscall, brk        lane-0-only faults
//   int_pending,
//   interrupts_enabled  interrupt request and global enable
//   exn_ack             control unit consumed the pending exception
//   lane_ec             combinational per-lane codes, lane i at [5i+4:5i]
//   exn_valid/code/lane/pc  captured exception
//   flush               one-cycle pulse on the cycle after capture
//   busy                exception pending or draining
module mcpu_core_exn_arbiter #(
    parameter int LANES     = 4,
    parameter int PC_W      = 28,
    parameter int DRAIN_CYC = 2,
    localparam int LW       = $clog2(LANES)
) (
    input  logic               clkrst_core_clk,
    input  logic               clkrst_core_rst_n,
    input  logic               pc_valid,
    input  logic [PC_W-1:0]    pc_pc,
    input  logic               inst_pf,
    input  logic [LANES-1:0]   invalid,
    input  logic [LANES-1:0]   data_pf,
    input  logic               dup_dest,
    input  logic               div_zero,
    input  logic               syscall,
    input  logic               brk,
    input  logic               int_pending,
    input  logic               interrupts_enabled,
    input  logic               exn_ack,
    output logic [5*LANES-1:0] lane_ec,
    output logic               exn_valid,
    output logic [4:0]         exn_code,
    output logic [LW-1:0]      exn_lane,
    output logic [PC_W-1:0]    exn_pc,
    output logic               flush,
    output logic               busy
);

    localparam logic [4:0] EC_NOERR     = 5'd0;
    localparam logic [4:0] EC_ILL       = 5'd1;
    localparam logic [4:0] EC_INST_PF   = 5'd2;
    localparam logic [4:0] EC_DATA_PF   = 5'd3;
    localparam logic [4:0] EC_DUP_DEST  = 5'd4;
    localparam logic [4:0] EC_DIVZERO   = 5'd5;
    localparam logic [4:0] EC_SYSCALL   = 5'd6;
    localparam logic [4:0] EC_BREAK     = 5'd7;
    localparam logic [4:0] EC_INTERRUPT = 5'd8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PEND  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            exn_valid_q, exn_valid_d;
    logic [4:0]      exn_code_q, exn_code_d;
    logic [LW-1:0]   exn_lane_q, exn_lane_d;
    logic [PC_W-1:0] exn_pc_q, exn_pc_d;
    logic            flush_q, flush_d;
    logic            busy_q, busy_d;

    logic            any_fault_s;
    logic [LW-1:0]   sel_lane_s;
    logic [4:0]      sel_code_s;
    logic            detect_s;

    // Per-lane priority encoding of fault conditions.
    always_comb begin
        logic [4:0] code;
        lane_ec = '0;
        for (int i = 0; i < LANES; i++) begin
            code = EC_NOERR;
            if (i == 0) begin
                if (inst_pf)                                code = EC_INST_PF;
                else if (invalid[0])                        code = EC_ILL;
                else if (dup_dest)                          code = EC_DUP_DEST;
                else if (data_pf[0])                        code = EC_DATA_PF;
                else if (div_zero)                          code = EC_DIVZERO;
                else if (syscall)                           code = EC_SYSCALL;
                else if (brk)                               code = EC_BREAK;
                else if (int_pending && interrupts_enabled) code = EC_INTERRUPT;
                else                                        code = EC_NOERR;
            end else begin
                if (invalid[i])      code = EC_ILL;
                else if (data_pf[i]) code = EC_DATA_PF;
                else                 code = EC_NOERR;
            end
            lane_ec[5*i +: 5] = code;
        end
    end

    // Lowest faulting lane: scan downward so the lowest hit is written last.
    always_comb begin
        logic hit;
        any_fault_s = 1'b0;
        sel_lane_s  = '0;
        sel_code_s  = EC_NOERR;
        for (int i = LANES - 1; i >= 0; i--) begin
            hit         = (lane_ec[5*i +: 5] != EC_NOERR);
            any_fault_s = any_fault_s | hit;
            sel_lane_s  = hit ? LW'(i) : sel_lane_s;
            sel_code_s  = hit ? lane_ec[5*i +: 5] : sel_code_s;
        end
    end

    assign detect_s = pc_valid && (state_q == ST_IDLE) && any_fault_s;

    // Next-state logic for capture, acknowledge and drain sequencing.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        exn_valid_d = exn_valid_q;
        exn_code_d  = exn_code_q;
        exn_lane_d  = exn_lane_q;
        exn_pc_d    = exn_pc_q;
        flush_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // exn_ack is deliberately not looked at here.
                if (detect_s) begin
                    state_d     = ST_PEND;
                    exn_valid_d = 1'b1;
                    exn_code_d  = sel_code_s;
                    exn_lane_d  = sel_lane_s;
                    exn_pc_d    = pc_pc;
                    flush_d     = 1'b1;
                end else begin
                    cnt_d = 4'd0;
                end
            end
            ST_PEND: begin
                if (exn_ack) begin
                    state_d     = ST_DRAIN;
                    exn_valid_d = 1'b0;
                    cnt_d       = 4'(DRAIN_CYC - 1);
                end else begin
                    state_d = ST_PEND;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cnt_d       = 4'd0;
                exn_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            exn_valid_q <= 1'b0;
            exn_code_q  <= EC_NOERR;
            exn_lane_q  <= '0;
            exn_pc_q    <= '0;
            flush_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            exn_valid_q <= exn_valid_d;
            exn_code_q  <= exn_code_d;
            exn_lane_q  <= exn_lane_d;
            exn_pc_q    <= exn_pc_d;
            flush_q     <= flush_d;
            busy_q      <= busy_d;
        end
    end

    assign exn_valid = exn_valid_q;
    assign exn_code  = exn_code_q;
    assign exn_lane  = exn_lane_q;
    assign exn_pc    = exn_pc_q;
    assign flush     = flush_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mcpu_core_exn_arbiter.sv
module tb_mcpu_core_exn_arbiter;

    localparam logic [4:0] C_N   = 5'd0;
    localparam logic [4:0] C_ILL = 5'd1;
    localparam logic [4:0] C_IPF = 5'd2;
    localparam logic [4:0] C_DPF = 5'd3;
    localparam logic [4:0] C_DUP = 5'd4;
    localparam logic [4:0] C_DZ  = 5'd5;
    localparam logic [4:0] C_SC  = 5'd6;
    localparam logic [4:0] C_BK  = 5'd7;
    localparam logic [4:0] C_INT = 5'd8;
    localparam int DRAIN = 2;

    typedef struct {
        logic        pv;
        logic [31:0] pc;
        logic        ipf;
        logic [7:0]  inv;
        logic [7:0]  dpf;
        logic        dd, dz, sc, bk, ip, ie, ack;
    } stim_t;

    typedef struct {
        logic        ipf;
        logic [3:0]  inv, dpf;
        logic        dd, dz, sc, bk, ip, ie;
        logic [19:0] exp_ec;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 4-lane DUT signals
    logic        pc_valid, inst_pf, dup_dest, div_zero, syscall, brk;
    logic        int_pending, interrupts_enabled, exn_ack;
    logic [27:0] pc_pc, exn_pc;
    logic [3:0]  invalid, data_pf;
    logic [19:0] lane_ec;
    logic        exn_valid, flush, busy;
    logic [4:0]  exn_code;
    logic [1:0]  exn_lane;

    // 8-lane DUT signals
    logic        b_pc_valid, b_ack;
    logic [31:0] b_pc_pc, b_exn_pc;
    logic [7:0]  b_data_pf;
    logic [39:0] b_lane_ec;
    logic        b_exn_valid, b_flush, b_busy;
    logic [4:0]  b_exn_code;
    logic [2:0]  b_exn_lane;

    int n_tests = 0;
    int n_fail  = 0;

    mcpu_core_exn_arbiter dut (
        .clkrst_core_clk(clk), .clkrst_core_rst_n(rst_n),
        .pc_valid(pc_valid), .pc_pc(pc_pc), .inst_pf(inst_pf),
        .invalid(invalid), .data_pf(data_pf), .dup_dest(dup_dest),
        .div_zero(div_zero), .syscall(syscall), .brk(brk),
        .int_pending(int_pending), .interrupts_enabled(interrupts_enabled),
        .exn_ack(exn_ack), .lane_ec(lane_ec), .exn_valid(exn_valid),
        .exn_code(exn_code), .exn_lane(exn_lane), .exn_pc(exn_pc),
        .flush(flush), .busy(busy)
    );

    mcpu_core_exn_arbiter #(.LANES(8), .PC_W(32), .DRAIN_CYC(1)) dut8 (
        .clkrst_core_clk(clk), .clkrst_core_rst_n(rst_n),
        .pc_valid(b_pc_valid), .pc_pc(b_pc_pc), .inst_pf(1'b0),
        .invalid(8'h00), .data_pf(b_data_pf), .dup_dest(1'b0),
        .div_zero(1'b0), .syscall(1'b0), .brk(1'b0),
        .int_pending(1'b0), .interrupts_enabled(1'b0),
        .exn_ack(b_ack), .lane_ec(b_lane_ec), .exn_valid(b_exn_valid),
        .exn_code(b_exn_code), .exn_lane(b_exn_lane), .exn_pc(b_exn_pc),
        .flush(b_flush), .busy(b_busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input stim_t s);
        pc_valid = s.pv; pc_pc = s.pc[27:0]; inst_pf = s.ipf;
        invalid = s.inv[3:0]; data_pf = s.dpf[3:0];
        dup_dest = s.dd; div_zero = s.dz; syscall = s.sc; brk = s.bk;
        int_pending = s.ip; interrupts_enabled = s.ie; exn_ack = s.ack;
    endtask

    function automatic stim_t idle_stim();
        stim_t s;
        s = '{pv: 1'b0, pc: 32'h0, ipf: 1'b0, inv: 8'h0, dpf: 8'h0,
              dd: 1'b0, dz: 1'b0, sc: 1'b0, bk: 1'b0, ip: 1'b0, ie: 1'b0, ack: 1'b0};
        return s;
    endfunction

    // Reference: walk the priority list for the lane, first true condition wins.
    function automatic logic [4:0] ref_code(input int lane, input stim_t s);
        logic [4:0] ord [8];
        logic       hit [8];
        if (lane == 0) begin
            ord = '{C_IPF, C_ILL, C_DUP, C_DPF, C_DZ, C_SC, C_BK, C_INT};
            hit = '{s.ipf, s.inv[0], s.dd, s.dpf[0], s.dz, s.sc, s.bk, s.ip & s.ie};
        end else begin
            ord = '{C_ILL, C_DPF, C_N, C_N, C_N, C_N, C_N, C_N};
            hit = '{s.inv[lane], s.dpf[lane], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        end
        ref_code = C_N;
        for (int k = 7; k >= 0; k--) begin
            if (hit[k]) ref_code = ord[k];
        end
    endfunction

    function automatic logic [19:0] ref_ec(input stim_t s);
        ref_ec = {ref_code(3, s), ref_code(2, s), ref_code(1, s), ref_code(0, s)};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 64'(exn_valid), 64'(1'b0));
        check({tag, "_flush"}, 64'(flush), 64'(1'b0));
        check({tag, "_busy"},  64'(busy), 64'(1'b0));
        check({tag, "_code"},  64'(exn_code), 64'(C_N));
        check({tag, "_lane"},  64'(exn_lane), 64'(0));
        check({tag, "_pc"},    64'(exn_pc), 64'(0));
    endtask

    // ack in PEND, then wait out the drain so the DUT is back in IDLE
    task automatic ack_and_drain();
        stim_t s;
        s = idle_stim();
        s.ack = 1'b1;
        apply(s);
        tick();
        apply(idle_stim());
        for (int i = 0; i < DRAIN; i++) tick();
    endtask

    // reference model state for the random phase
    logic        m_pend, m_valid, m_flush;
    int          m_left;
    logic [4:0]  m_code;
    logic [1:0]  m_lane;
    logic [27:0] m_pc;

    vec_t vecs [12];

    initial begin
        stim_t s;
        logic [19:0] ec;

        vecs[0]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {C_N, C_N, C_N, C_N}};
        vecs[1]  = '{1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {C_N, C_N, C_N, C_IPF}};
        vecs[2]  = '{1'b0, 4'b0101, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {C_N, C_ILL, C_DPF, C_ILL}};
        vecs[3]  = '{1'b0, 4'b0000, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {C_N, C_N, C_N, C_DUP}};
        vecs[4]  = '{1'b0, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {C_DPF, C_DPF, C_DPF, C_DPF}};
        vecs[5]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, {C_N, C_N, C_N, C_DZ}};
        vecs[6]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, {C_N, C_N, C_N, C_SC}};
        vecs[7]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, {C_N, C_N, C_N, C_BK}};
        vecs[8]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, {C_N, C_N, C_N, C_INT}};
        vecs[9]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, {C_N, C_N, C_N, C_N}};
        vecs[10] = '{1'b0, 4'b1000, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {C_ILL, C_N, C_N, C_N}};
        vecs[11] = '{1'b0, 4'b1110, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, {C_ILL, C_ILL, C_ILL, C_DUP}};

        apply(idle_stim());
        b_pc_valid = 1'b0; b_pc_pc = 32'h0; b_data_pf = 8'h00; b_ack = 1'b0;
        #12;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // lane_ec table with pc_valid=0: codes visible, nothing captured
        for (int v = 0; v < 12; v++) begin
            s = idle_stim();
            s.ipf = vecs[v].ipf; s.inv = {4'h0, vecs[v].inv}; s.dpf = {4'h0, vecs[v].dpf};
            s.dd = vecs[v].dd; s.dz = vecs[v].dz; s.sc = vecs[v].sc; s.bk = vecs[v].bk;
            s.ip = vecs[v].ip; s.ie = vecs[v].ie;
            apply(s);
            #1;
            check($sformatf("table%0d_ec", v), 64'(lane_ec), 64'(vecs[v].exp_ec));
            tick();
            check($sformatf("table%0d_nocap", v), 64'(exn_valid), 64'(1'b0));
        end

        // lowest faulting lane wins; capture after one edge, single flush
        s = idle_stim();
        s.pv = 1'b1; s.pc = 32'h123; s.inv = 8'b0100; s.dpf = 8'b1000;
        apply(s);
        #1;
        check("cap1_ec", 64'(lane_ec), 64'({C_DPF, C_ILL, C_N, C_N}));
        tick();
        check("cap1_valid", 64'(exn_valid), 64'(1'b1));
        check("cap1_code",  64'(exn_code), 64'(C_ILL));
        check("cap1_lane",  64'(exn_lane), 64'(2));
        check("cap1_pc",    64'(exn_pc), 64'(28'h123));
        check("cap1_flush", 64'(flush), 64'(1'b1));
        check("cap1_busy",  64'(busy), 64'(1'b1));
        // new faults held in PEND are ignored
        s = idle_stim();
        s.pv = 1'b1; s.pc = 32'h456; s.dpf = 8'b0001;
        apply(s);
        for (int i = 0; i < 5; i++) tick();
        check("hold_flush", 64'(flush), 64'(1'b0));
        check("hold_code",  64'(exn_code), 64'(C_ILL));
        check("hold_lane",  64'(exn_lane), 64'(2));
        check("hold_pc",    64'(exn_pc), 64'(28'h123));
        check("hold_valid", 64'(exn_valid), 64'(1'b1));
        s.ack = 1'b1;
        apply(s);
        tick();
        check("ack_valid", 64'(exn_valid), 64'(1'b0));
        check("drain1_busy", 64'(busy), 64'(1'b1));
        s.ack = 1'b0;
        apply(s);
        tick();
        check("drain2_busy", 64'(busy), 64'(1'b1));
        check("drain2_valid", 64'(exn_valid), 64'(1'b0));
        tick();
        check("idle_busy", 64'(busy), 64'(1'b0));
        check("idle_valid", 64'(exn_valid), 64'(1'b0));
        tick();
        check("recap_valid", 64'(exn_valid), 64'(1'b1));
        check("recap_code",  64'(exn_code), 64'(C_DPF));
        check("recap_lane",  64'(exn_lane), 64'(0));
        check("recap_pc",    64'(exn_pc), 64'(28'h456));
        ack_and_drain();

        // inst_pf outranks syscall and interrupt
        s = idle_stim();
        s.pv = 1'b1; s.pc = 32'h77; s.ipf = 1'b1; s.sc = 1'b1; s.ip = 1'b1; s.ie = 1'b1;
        apply(s);
        tick();
        check("ipf_code", 64'(exn_code), 64'(C_IPF));
        check("ipf_lane", 64'(exn_lane), 64'(0));
        ack_and_drain();

        // masked interrupt, and interrupt without pc_valid: no capture
        s = idle_stim();
        s.pv = 1'b1; s.ip = 1'b1; s.ie = 1'b0;
        apply(s);
        tick();
        check("int_masked", 64'(exn_valid), 64'(1'b0));
        s.pv = 1'b0; s.ie = 1'b1;
        apply(s);
        tick();
        check("int_nopv", 64'(exn_valid), 64'(1'b0));
        // interrupt captured; ack in the same IDLE cycle is ignored
        s.pv = 1'b1; s.ack = 1'b1;
        apply(s);
        tick();
        check("int_valid", 64'(exn_valid), 64'(1'b1));
        check("int_code",  64'(exn_code), 64'(C_INT));
        // enable dropping while pending does not cancel it
        s = idle_stim();
        apply(s);
        tick();
        check("int_keep_valid", 64'(exn_valid), 64'(1'b1));
        check("int_keep_code",  64'(exn_code), 64'(C_INT));

        // asynchronous reset mid-PEND discards and suppresses flush
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_pend");
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_noflush", 64'(flush), 64'(1'b0));
        check("rst_novalid", 64'(exn_valid), 64'(1'b0));
        // first edge after release can capture
        s = idle_stim();
        s.pv = 1'b1; s.pc = 32'h9; s.dpf = 8'b0010;
        apply(s);
        tick();
        check("postrst_valid", 64'(exn_valid), 64'(1'b1));
        check("postrst_lane",  64'(exn_lane), 64'(1));
        ack_and_drain();

        // 8-lane, 32-bit PC, single drain cycle
        b_pc_valid = 1'b1; b_pc_pc = 32'hDEAD_BEEF; b_data_pf = 8'h80;
        tick();
        b_pc_valid = 1'b0; b_data_pf = 8'h00;
        check("l8_valid", 64'(b_exn_valid), 64'(1'b1));
        check("l8_code",  64'(b_exn_code), 64'(C_DPF));
        check("l8_lane",  64'(b_exn_lane), 64'(7));
        check("l8_pc",    64'(b_exn_pc), 64'(32'hDEAD_BEEF));
        check("l8_flush", 64'(b_flush), 64'(1'b1));
        b_ack = 1'b1;
        tick();
        b_ack = 1'b0;
        check("l8_drain_busy", 64'(b_busy), 64'(1'b1));
        check("l8_drain_valid", 64'(b_exn_valid), 64'(1'b0));
        tick();
        check("l8_idle_busy", 64'(b_busy), 64'(1'b0));

        // randomized run against the reference model (DUT is IDLE here)
        m_pend = 1'b0; m_valid = 1'b0; m_flush = 1'b0; m_left = 0;
        m_code = exn_code; m_lane = exn_lane; m_pc = exn_pc;
        for (int cyc = 0; cyc < 400; cyc++) begin
            s.pv  = 1'($urandom_range(0, 1));
            s.pc  = $urandom;
            s.ipf = ($urandom_range(0, 15) == 0);
            s.inv = 8'($urandom & $urandom & $urandom);
            s.dpf = 8'($urandom & $urandom & $urandom);
            s.dd  = ($urandom_range(0, 9) == 0);
            s.dz  = ($urandom_range(0, 9) == 0);
            s.sc  = ($urandom_range(0, 9) == 0);
            s.bk  = ($urandom_range(0, 9) == 0);
            s.ip  = ($urandom_range(0, 3) == 0);
            s.ie  = 1'($urandom_range(0, 1));
            s.ack = ($urandom_range(0, 3) == 0);
            apply(s);
            #1;
            ec = ref_ec(s);
            check("rnd_ec", 64'(lane_ec), 64'(ec));
            m_flush = 1'b0;
            if (m_pend) begin
                if (s.ack) begin
                    m_pend = 1'b0; m_valid = 1'b0; m_left = DRAIN;
                end
            end else if (m_left > 0) begin
                m_left--;
            end else if (s.pv && ec != 20'h0) begin
                for (int l = 3; l >= 0; l--) begin
                    if (ref_code(l, s) != C_N) begin
                        m_lane = 2'(l);
                        m_code = ref_code(l, s);
                    end
                end
                m_pc = s.pc[27:0]; m_pend = 1'b1; m_valid = 1'b1; m_flush = 1'b1;
            end
            tick();
            check("rnd_valid", 64'(exn_valid), 64'(m_valid));
            check("rnd_flush", 64'(flush), 64'(m_flush));
            check("rnd_busy",  64'(busy), 64'(m_pend || m_left > 0));
            if (m_valid) begin
                check("rnd_code", 64'(exn_code), 64'(m_code));
                check("rnd_lane", 64'(exn_lane), 64'(m_lane));
                check("rnd_pc",   64'(exn_pc), 64'(m_pc));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
